axi_stride_rd_master: RTL and testbench

Upstream AXI read client that drives the prefetcher's slave AR/R ports with a programmable strided burst stream, emulating the accelerator access pattern. It issues cfg_num_req read bursts at base, base+stride, base+2*stride, and so on. It keeps up to MAX_OUTSTANDING bursts in flight, consumes every R beat, and checks data, last and ID against an expected incrementing pattern. Error and beat counters are exposed for benches and for on-chip self-test.

---
 rtl/axi_stride_rd_master.sv | 175 +++++++++++++++++
 tb/tb_axi_stride_rd_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stride_rd_master.sv
// Strided AXI read master: issues equal-length bursts at base + k*stride and
// checks every returned beat against an incrementing data pattern, RID and RLAST.
module axi_stride_rd_master #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int ID_WIDTH        = 8,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int CNT_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      cfg_base,
    input  logic [ADDR_WIDTH-1:0]      cfg_stride,
    input  logic [BURST_LEN_WIDTH-1:0] cfg_len,
    input  logic [CNT_WIDTH-1:0]       cfg_num_req,
    input  logic [ID_WIDTH-1:0]        cfg_id,
    input  logic [DATA_WIDTH-1:0]      cfg_data_seed,
    input  logic                       cfg_check_en,
    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ADDR_WIDTH-1:0]      m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
    output logic [ID_WIDTH-1:0]        m_ar_id,
    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [DATA_WIDTH-1:0]      m_r_data,
    input  logic                       m_r_last,
    input  logic [ID_WIDTH-1:0]        m_r_id,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_WIDTH-1:0]       err_cnt,
    output logic [2*CNT_WIDTH-1:0]     beat_cnt,
    output logic [DATA_WIDTH-1:0]      first_err_data
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; m_ar_addr/len/id are held while m_ar_valid is high and m_ar_ready low.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [CNT_WIDTH-1:0]       MAX_OUT  = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0]       CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [2*CNT_WIDTH-1:0]     BEAT_ONE = (2*CNT_WIDTH)'(1);
    localparam logic [DATA_WIDTH-1:0]      DATA_ONE = DATA_WIDTH'(1);
    localparam logic [BURST_LEN_WIDTH-1:0] LEN_ONE  = BURST_LEN_WIDTH'(1);

    state_t                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      addr_q, addr_d, stride_q, stride_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d, beat_idx_q, beat_idx_d;
    logic [CNT_WIDTH-1:0]       num_q, num_d, issued_q, issued_d, out_q, out_d;
    logic [CNT_WIDTH-1:0]       err_q, err_d;
    logic [ID_WIDTH-1:0]        id_q, id_d;
    logic [DATA_WIDTH-1:0]      exp_q, exp_d, first_q, first_d;
    logic [2*CNT_WIDTH-1:0]     beat_cnt_q, beat_cnt_d;
    logic                       chk_q, chk_d;
    logic                       ar_valid, r_ready, ar_hs, r_hs, last_beat, beat_err;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        len_d      = len_q;
        num_d      = num_q;
        id_d       = id_q;
        exp_d      = exp_q;
        chk_d      = chk_q;
        issued_d   = issued_q;
        out_d      = out_q;
        beat_idx_d = beat_idx_q;
        err_d      = err_q;
        first_d    = first_q;
        beat_cnt_d = beat_cnt_q;

        ar_valid  = (state_q == S_RUN) && (issued_q < num_q) && (out_q < MAX_OUT);
        // Only accept R beats that belong to an issued burst.
        r_ready   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (out_q != '0);
        ar_hs     = ar_valid && m_ar_ready;
        r_hs      = r_ready && m_r_valid;
        last_beat = (beat_idx_q == len_q);
        beat_err  = (chk_q && (m_r_data != exp_q)) || (m_r_id != id_q) ||
                    (m_r_last != last_beat);

        if (ar_hs) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + CNT_ONE;
        end

        if (r_hs) begin
            beat_cnt_d = beat_cnt_q + BEAT_ONE;
            exp_d      = exp_q + DATA_ONE;
            beat_idx_d = last_beat ? '0 : beat_idx_q + LEN_ONE;
            if (beat_err) begin
                if (err_q != '1) err_d = err_q + CNT_ONE;
                if (err_q == '0) first_d = m_r_data;
            end
        end

        // Burst completion is counted by beat position, independent of RLAST.
        case ({ar_hs, r_hs && last_beat})
            2'b10:   out_d = out_q + CNT_ONE;
            2'b01:   out_d = out_q - CNT_ONE;
            default: out_d = out_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d     = cfg_base;
                    stride_d   = cfg_stride;
                    len_d      = cfg_len;
                    num_d      = cfg_num_req;
                    id_d       = cfg_id;
                    exp_d      = cfg_data_seed;
                    chk_d      = cfg_check_en;
                    issued_d   = '0;
                    out_d      = '0;
                    beat_idx_d = '0;
                    err_d      = '0;
                    first_d    = '0;
                    beat_cnt_d = '0;
                    state_d    = (cfg_num_req == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN:   if (issued_d == num_q) state_d = S_DRAIN;
            S_DRAIN: if (out_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            num_q      <= '0;
            id_q       <= '0;
            exp_q      <= '0;
            chk_q      <= 1'b0;
            issued_q   <= '0;
            out_q      <= '0;
            beat_idx_q <= '0;
            err_q      <= '0;
            first_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            num_q      <= num_d;
            id_q       <= id_d;
            exp_q      <= exp_d;
            chk_q      <= chk_d;
            issued_q   <= issued_d;
            out_q      <= out_d;
            beat_idx_q <= beat_idx_d;
            err_q      <= err_d;
            first_q    <= first_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign m_ar_valid     = ar_valid;
    assign m_ar_addr      = addr_q;
    assign m_ar_len       = len_q;
    assign m_ar_id        = id_q;
    assign m_r_ready      = r_ready;
    assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign err_cnt        = err_q;
    assign beat_cnt       = beat_cnt_q;
    assign first_err_data = first_q;
endmodule

// File: tb/tb_axi_stride_rd_master.sv
// Bench for axi_stride_rd_master: an AXI slave model feeding planted faults, a
// table of directed runs, hand-written corner sequences and randomized runs.
module tb_axi_stride_rd_master;
    localparam int AW = 16, DW = 8, IW = 8, LW = 8, CW = 8, MO = 4;

    logic          clk = 1'b0;
    logic          rst, start, cfg_check_en;
    logic [AW-1:0] cfg_base, cfg_stride, m_ar_addr;
    logic [LW-1:0] cfg_len, m_ar_len;
    logic [CW-1:0] cfg_num_req, err_cnt;
    logic [IW-1:0] cfg_id, m_ar_id, m_r_id;
    logic [DW-1:0] cfg_data_seed, m_r_data, first_err_data;
    logic          m_ar_valid, m_ar_ready, m_r_valid, m_r_ready, m_r_last, busy, done;
    logic [2*CW-1:0] beat_cnt;

    always #5 clk = ~clk;

    axi_stride_rd_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .BURST_LEN_WIDTH(LW),
        .CNT_WIDTH(CW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
        .cfg_len(cfg_len), .cfg_num_req(cfg_num_req), .cfg_id(cfg_id),
        .cfg_data_seed(cfg_data_seed), .cfg_check_en(cfg_check_en),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_id(m_r_id), .busy(busy), .done(done),
        .err_cnt(err_cnt), .beat_cnt(beat_cnt), .first_err_data(first_err_data)
    );

    typedef struct {
        logic [AW-1:0] base, stride;
        logic [LW-1:0] len;
        logic [CW-1:0] num;
        logic [IW-1:0] id;
        logic [DW-1:0] seed;
        logic          check_en;
        int            corrupt_g;
        logic [DW-1:0] corrupt_val;
        int            drop_b;
        int            badid_g;
        logic [IW-1:0] badid_val;
        logic [CW-1:0] exp_err;
        logic [DW-1:0] exp_first;
        logic          ar_rand, r_rand;
    } vec_t;

    typedef struct { logic [AW-1:0] addr; logic [LW-1:0] len; logic [IW-1:0] id; int cyc; } ar_rec_t;
    typedef struct { logic [DW-1:0] data; logic last; logic [IW-1:0] id; } beat_t;

    int      n_checks = 0, n_errs = 0;
    vec_t    cur;
    ar_rec_t ar_log[$];
    beat_t   beat_q[$];
    int      cyc = 0, r_budget = 0, r_hs_cyc = -1, done_cnt = 0;
    logic    r_taken = 1'b0, prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #3;
    endtask

    function automatic vec_t mk(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                                input logic [LW-1:0] len, input logic [CW-1:0] num,
                                input logic [IW-1:0] id, input logic [DW-1:0] seed,
                                input logic ce, input int cg, input logic [DW-1:0] cv,
                                input int db, input int bg, input logic [IW-1:0] bv,
                                input logic [CW-1:0] ee, input logic [DW-1:0] ef,
                                input logic ar_r, input logic r_r);
        vec_t v;
        v.base = base; v.stride = stride; v.len = len; v.num = num; v.id = id;
        v.seed = seed; v.check_en = ce; v.corrupt_g = cg; v.corrupt_val = cv;
        v.drop_b = db; v.badid_g = bg; v.badid_val = bv; v.exp_err = ee;
        v.exp_first = ef; v.ar_rand = ar_r; v.r_rand = r_r;
        return v;
    endfunction

    // Reference: walk the whole run beat by beat and apply the error rules directly.
    function automatic void model_errs(input vec_t v, output logic [CW-1:0] e,
                                       output logic [DW-1:0] f);
        int per, total;
        per   = int'(v.len) + 1;
        total = int'(v.num) * per;
        e = '0;
        f = '0;
        for (int g = 0; g < total; g++) begin
            logic [DW-1:0] want, sent;
            logic          is_last, sent_last, bad;
            want      = v.seed + DW'(g);
            sent      = (g == v.corrupt_g) ? v.corrupt_val : want;
            is_last   = ((g % per) == per - 1);
            sent_last = is_last && ((g / per) != v.drop_b);
            bad = (v.check_en && (sent != want)) || ((g == v.badid_g) && (v.badid_val != v.id)) ||
                  (sent_last != is_last);
            if (bad) begin
                if (e == '0) f = sent;
                if (e != '1) e = e + 1'b1;
            end
        end
    endfunction

    // Slave: drives ready/valid at negedge, then records the handshakes due at the next posedge.
    initial begin
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_last   = 1'b0;
        m_r_id     = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (r_taken || beat_q.size() == 0) m_r_valid = 1'b0;
            r_taken = 1'b0;
            m_ar_ready = cur.ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!m_r_valid && beat_q.size() > 0 && r_budget != 0 &&
                (!cur.r_rand || $urandom_range(0, 2) != 0)) begin
                m_r_valid = 1'b1;
                m_r_data  = beat_q[0].data;
                m_r_last  = beat_q[0].last;
                m_r_id    = beat_q[0].id;
            end
            #1;
            if (prev_stall && !rst) chk("ar_hold", {m_ar_valid, m_ar_addr}, {1'b1, prev_addr});
            prev_stall = m_ar_valid && !m_ar_ready;
            prev_addr  = m_ar_addr;
            if (m_ar_valid && m_ar_ready) begin
                int b, per;
                beat_t bt;
                b   = ar_log.size();
                per = int'(cur.len) + 1;
                ar_log.push_back('{addr: m_ar_addr, len: m_ar_len, id: m_ar_id, cyc: cyc});
                for (int i = 0; i < per; i++) begin
                    int g;
                    g       = b * per + i;
                    bt.data = (g == cur.corrupt_g) ? cur.corrupt_val : cur.seed + DW'(g);
                    bt.last = (i == per - 1) && (b != cur.drop_b);
                    bt.id   = (g == cur.badid_g) ? cur.badid_val : cur.id;
                    beat_q.push_back(bt);
                end
            end
            if (m_r_valid && m_r_ready) begin
                void'(beat_q.pop_front());
                if (r_budget > 0) r_budget--;
                r_hs_cyc = cyc;
                r_taken  = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            chk("busy_at_done", busy, 0);
        end
    end

    task automatic start_run(input vec_t v, input int budget);
        cur = v;
        ar_log.delete();
        beat_q.delete();
        done_cnt = 0;
        r_budget = budget;
        cfg_base = v.base; cfg_stride = v.stride; cfg_len = v.len; cfg_num_req = v.num;
        cfg_id = v.id; cfg_data_seed = v.seed; cfg_check_en = v.check_en;
        start = 1'b1;
        tick;
        start = 1'b0;
        cfg_base = AW'($urandom); cfg_stride = AW'($urandom); cfg_len = LW'($urandom);
        cfg_num_req = CW'($urandom); cfg_id = IW'($urandom); cfg_data_seed = DW'($urandom);
        cfg_check_en = 1'($urandom);
    endtask

    task automatic wait_ar(input int n, input int budget);
        int t = 0;
        while (ar_log.size() < n && t < budget) begin
            tick;
            t++;
        end
        chk("ar_count_reached", ar_log.size() >= n, 1);
    endtask

    task automatic finish_run(input vec_t v, input logic [CW-1:0] ee, input logic [DW-1:0] ef);
        int t = 0;
        logic [AW-1:0] a;
        while (done_cnt == 0 && t < 2000) begin
            tick;
            t++;
        end
        chk("done_seen", done_cnt != 0, 1);
        tick;
        tick;
        chk("busy_after_done", busy, 0);
        chk("done_pulses", done_cnt, 1);
        chk("ar_count", ar_log.size(), v.num);
        a = v.base;
        for (int i = 0; i < ar_log.size() && i < int'(v.num); i++) begin
            chk($sformatf("ar_addr[%0d]", i), ar_log[i].addr, a);
            chk($sformatf("ar_len[%0d]", i), ar_log[i].len, v.len);
            chk($sformatf("ar_id[%0d]", i), ar_log[i].id, v.id);
            a = a + v.stride;
        end
        chk("beat_cnt", beat_cnt, (2*CW)'(int'(v.num) * (int'(v.len) + 1)));
        chk("err_cnt", err_cnt, ee);
        chk("first_err_data", first_err_data, ef);
    endtask

    vec_t tbl[4];

    initial begin
        vec_t v;
        logic [CW-1:0] e;
        logic [DW-1:0] f;
        cur = mk('0, '0, '0, '0, '0, '0, 1'b0, -1, '0, -1, -1, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1; start = 1'b0;
        cfg_base = '0; cfg_stride = '0; cfg_len = '0; cfg_num_req = '0;
        cfg_id = '0; cfg_data_seed = '0; cfg_check_en = 1'b0;

        tbl[0] = mk(16'h0eef, 16'h0004, 8'd2, 8'd3, 8'h11, 8'h00, 1'b1, -1, 8'h00, -1, -1, 8'h00,
                    8'd0, 8'h00, 1'b0, 1'b0);
        tbl[1] = mk(16'h0100, 16'h0010, 8'd3, 8'd2, 8'h22, 8'h00, 1'b1, 4, 8'hAA, -1, -1, 8'h00,
                    8'd1, 8'hAA, 1'b1, 1'b1);
        tbl[2] = mk(16'h0100, 16'h0010, 8'd3, 8'd2, 8'h22, 8'h00, 1'b0, 4, 8'hAA, -1, -1, 8'h00,
                    8'd0, 8'h00, 1'b1, 1'b1);
        tbl[3] = mk(16'h2000, 16'h0040, 8'd1, 8'd3, 8'h05, 8'h20, 1'b1, -1, 8'h00, 1, 0, 8'h03,
                    8'd2, 8'h20, 1'b1, 1'b1);

        repeat (3) tick;
        chk("rst_outputs", {m_ar_valid, m_r_ready, busy, done}, 0);
        chk("rst_counters", {err_cnt, beat_cnt, first_err_data}, 0);
        chk("rst_ar_fields", {m_ar_addr, m_ar_len, m_ar_id}, 0);
        rst = 1'b0;
        tick;

        for (int k = 0; k < 4; k++) begin
            start_run(tbl[k], -1);
            if (k == 0) begin
                chk("ar_valid_first", m_ar_valid, 1);
                chk("busy_after_start", busy, 1);
            end
            finish_run(tbl[k], tbl[k].exp_err, tbl[k].exp_first);
        end

        // Zero-length run goes straight to the completion pulse.
        v = mk(16'h1234, 16'h0001, 8'd0, 8'd0, 8'h01, 8'h00, 1'b1, -1, 8'h00, -1, -1, 8'h00,
               8'd0, 8'h00, 1'b0, 1'b0);
        start_run(v, -1);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ar_valid", m_ar_valid, 0);
        tick;
        chk("zero_done_low", done, 0);
        tick;
        chk("zero_done_pulses", done_cnt, 1);
        chk("zero_no_ar", ar_log.size(), 0);

        // Outstanding limit with R withheld, then one completion frees a slot.
        v = mk(16'h4000, 16'h0100, 8'd0, 8'd6, 8'h09, 8'h00, 1'b1, -1, 8'h00, -1, -1, 8'h00,
               8'd0, 8'h00, 1'b0, 1'b0);
        start_run(v, 0);
        wait_ar(MO, 20);
        repeat (5) tick;
        chk("limit_ar_count", ar_log.size(), MO);
        chk("limit_ar_valid", m_ar_valid, 0);
        r_budget = 1;
        wait_ar(MO + 1, 10);
        if (ar_log.size() > MO) chk("fifth_ar_latency", ar_log[MO].cyc, r_hs_cyc + 1);
        r_budget = -1;
        finish_run(v, 8'd0, 8'h00);

        // Negative stride wraps; reset during drain with beats still in flight.
        v = mk(16'h0002, 16'hFFFC, 8'd0, 8'd2, 8'h07, 8'h00, 1'b1, -1, 8'h00, -1, -1, 8'h00,
               8'd0, 8'h00, 1'b0, 1'b0);
        start_run(v, 0);
        wait_ar(2, 20);
        tick;
        if (ar_log.size() >= 2) begin
            chk("wrap_addr0", ar_log[0].addr, 16'h0002);
            chk("wrap_addr1", ar_log[1].addr, 16'hFFFE);
        end
        chk("drain_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {busy, m_ar_valid, m_r_ready}, 0);
        chk("midrst_err", err_cnt, 0);
        tick;
        rst = 1'b0;
        r_budget = -1;
        repeat (4) tick;
        chk("post_rst_r_ready", m_r_ready, 0);
        chk("post_rst_beats", beat_cnt, 0);
        chk("post_rst_unconsumed", beat_q.size(), 2);
        beat_q.delete();
        r_budget = 0;
        tick;

        for (int k = 0; k < 10; k++) begin
            int total;
            v.base = AW'($urandom); v.stride = AW'($urandom);
            v.len = LW'($urandom_range(0, 3)); v.num = CW'($urandom_range(1, 6));
            v.id = IW'($urandom); v.seed = DW'($urandom); v.check_en = 1'($urandom);
            total = int'(v.num) * (int'(v.len) + 1);
            v.corrupt_g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, total - 1)) : -1;
            v.corrupt_val = DW'($urandom);
            v.drop_b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(v.num) - 1)) : -1;
            v.badid_g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            v.badid_val = v.id ^ IW'($urandom_range(1, 255));
            v.ar_rand = 1'b1; v.r_rand = 1'b1;
            model_errs(v, e, f);
            start_run(v, -1);
            finish_run(v, e, f);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
